// File: rtl/vram_sram_arbiter.sv
// vram_sram_arbiter: two-master (VGA scan-out m0, CPU m1) arbiter onto one SRAM port
//   clkMem, rst        : clock, synchronous active-high reset
//   m0_stb/addr        : read-only scan-out request, held until m0_ack
//   m0_ack/dout        : one-cycle completion pulse and read data
//   m1_stb/addr/we/din : CPU request, held until m1_ack
//   m1_ack/dout/err    : one-cycle completion pulse, read data, timeout flag
//   s_stb/addr/we/din  : SRAM request, held through the transaction
//   s_dout/s_ack       : SRAM read data and one-cycle completion
module vram_sram_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        clkMem,
    input  logic        rst,
    input  logic        m0_stb,
    input  logic [31:0] m0_addr,
    output logic        m0_ack,
    output logic [47:0] m0_dout,
    input  logic        m1_stb,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_we,
    input  logic [31:0] m1_din,
    output logic        m1_ack,
    output logic [47:0] m1_dout,
    output logic        m1_err,
    output logic        s_stb,
    output logic [31:0] s_addr,
    output logic [3:0]  s_we,
    output logic [31:0] s_din,
    input  logic [47:0] s_dout,
    input  logic        s_ack
);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t        r_state;
    logic          r_gnt;
    logic [BW-1:0] r_burst;
    logic [7:0]    r_wait;
    logic          w_gnt1;
    logic          w_tmo;
    // m1 wins only when m0 is absent or m0 has used up its burst allowance
    assign w_gnt1 = m1_stb & (~m0_stb | (r_burst == BW'(MAX_BURST)));
    // last permitted BUSY cycle; an s_ack in this cycle still wins
    assign w_tmo  = r_wait == 8'(TIMEOUT - 1);
    always_ff @(posedge clkMem) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
            r_burst <= '0;
            r_wait  <= '0;
            s_stb   <= 1'b0;
            s_addr  <= '0;
            s_we    <= '0;
            s_din   <= '0;
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            m1_err  <= 1'b0;
            m0_dout <= '0;
            m1_dout <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // any path other than an m0 grant against a pending m1 clears the count;
                    // saturation is implicit since a full count forces the m1 grant
                    r_burst <= (!m1_stb || w_gnt1) ? '0 : r_burst + 1'b1;
                    if (m0_stb || m1_stb) begin
                        r_gnt   <= w_gnt1;
                        s_addr  <= w_gnt1 ? m1_addr : m0_addr;
                        s_we    <= w_gnt1 ? m1_we : 4'b0000;
                        s_din   <= w_gnt1 ? m1_din : 32'h0;
                        s_stb   <= 1'b1;
                        r_wait  <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ack || w_tmo) begin
                        s_stb   <= 1'b0;
                        r_state <= DONE;
                        if (r_gnt) begin
                            m1_dout <= s_ack ? s_dout : 48'h0;
                            m1_err  <= ~s_ack;
                            m1_ack  <= 1'b1;
                        end else begin
                            m0_dout <= s_ack ? s_dout : 48'h0;
                            m0_ack  <= 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                DONE: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    m1_err  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_sram_arbiter.sv
// tb_vram_sram_arbiter: directed self-checking bench for vram_sram_arbiter
module tb_vram_sram_arbiter;
    logic        clkMem = 1'b0;
    logic        rst = 1'b1;
    logic        m0_stb = 1'b0;
    logic [31:0] m0_addr = '0;
    logic        m0_ack;
    logic [47:0] m0_dout;
    logic        m1_stb = 1'b0;
    logic [31:0] m1_addr = '0;
    logic [3:0]  m1_we = '0;
    logic [31:0] m1_din = '0;
    logic        m1_ack;
    logic [47:0] m1_dout;
    logic        m1_err;
    logic        s_stb;
    logic [31:0] s_addr;
    logic [3:0]  s_we;
    logic [31:0] s_din;
    logic [47:0] s_dout = '0;
    logic        s_ack = 1'b0;
    int          errs = 0;
    int          checks = 0;

    vram_sram_arbiter dut (
        .clkMem(clkMem), .rst(rst),
        .m0_stb(m0_stb), .m0_addr(m0_addr), .m0_ack(m0_ack), .m0_dout(m0_dout),
        .m1_stb(m1_stb), .m1_addr(m1_addr), .m1_we(m1_we), .m1_din(m1_din),
        .m1_ack(m1_ack), .m1_dout(m1_dout), .m1_err(m1_err),
        .s_stb(s_stb), .s_addr(s_addr), .s_we(s_we), .s_din(s_din),
        .s_dout(s_dout), .s_ack(s_ack)
    );

    always #5 clkMem = ~clkMem;

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clkMem);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        logic exp_g;
        // reset state
        cyc(3);
        chk("rst_s_stb", 64'(s_stb), 0);
        chk("rst_s_addr", 64'(s_addr), 0);
        chk("rst_s_we", 64'(s_we), 0);
        chk("rst_s_din", 64'(s_din), 0);
        chk("rst_acks", 64'({m0_ack, m1_ack, m1_err}), 0);
        chk("rst_douts", 64'(m0_dout | m1_dout), 0);
        rst = 1'b0;
        cyc();
        // spurious s_ack in IDLE is ignored
        s_ack = 1'b1; s_dout = 48'hFFFF_FFFF_FFFF;
        cyc();
        s_ack = 1'b0;
        cyc();
        chk("spur_s_stb", 64'(s_stb), 0);
        chk("spur_acks", 64'({m0_ack, m1_ack}), 0);
        chk("spur_dout", 64'(m0_dout), 0);
        // m0 read: stb in cycle 0, s_ack in 2nd s_stb cycle, m0_ack in cycle 3
        m0_stb = 1'b1; m0_addr = 32'h12C;
        cyc();
        chk("m0_s_stb", 64'(s_stb), 1);
        chk("m0_s_addr", 64'(s_addr), 64'h12C);
        chk("m0_s_we", 64'(s_we), 0);
        chk("m0_s_din", 64'(s_din), 0);
        cyc();
        chk("m0_s_stb_hold", 64'(s_stb), 1);
        s_ack = 1'b1; s_dout = 48'hABCD_1234_5678;
        cyc();
        s_ack = 1'b0;
        chk("m0_ack", 64'({m0_ack, m1_ack}), 64'b10);
        chk("m0_dout", 64'(m0_dout), 64'hABCD_1234_5678);
        chk("m0_s_stb_drop", 64'(s_stb), 0);
        m0_stb = 1'b0;
        cyc();
        chk("m0_ack_pulse", 64'(m0_ack), 0);
        chk("m0_dout_hold", 64'(m0_dout), 64'hABCD_1234_5678);
        // m1 write
        m1_stb = 1'b1; m1_addr = 32'h40; m1_we = 4'b0011; m1_din = 32'hDEADBEEF;
        cyc();
        chk("m1w_s_stb", 64'(s_stb), 1);
        chk("m1w_s_addr", 64'(s_addr), 64'h40);
        chk("m1w_s_we", 64'(s_we), 64'h3);
        chk("m1w_s_din", 64'(s_din), 64'hDEADBEEF);
        s_ack = 1'b1; s_dout = 48'h1111_2222_3333;
        cyc();
        s_ack = 1'b0;
        chk("m1w_ack", 64'({m0_ack, m1_ack, m1_err}), 64'b010);
        chk("m1w_dout", 64'(m1_dout), 64'h1111_2222_3333);
        chk("m1w_m0_dout_hold", 64'(m0_dout), 64'hABCD_1234_5678);
        m1_stb = 1'b0;
        cyc();
        chk("m1w_ack_pulse", 64'({m1_ack, m1_err}), 0);
        // m0 dropping stb mid-transaction still completes
        m0_stb = 1'b1; m0_addr = 32'h5;
        cyc();
        m0_stb = 1'b0;
        cyc(2);
        chk("drop_s_stb", 64'(s_stb), 1);
        s_ack = 1'b1; s_dout = 48'h0000_0000_0077;
        cyc();
        s_ack = 1'b0;
        chk("drop_ack", 64'(m0_ack), 1);
        chk("drop_dout", 64'(m0_dout), 64'h77);
        cyc();
        // simultaneous requests with burst_cnt=0: m0 first, then m1
        m0_stb = 1'b1; m0_addr = 32'hA0;
        m1_stb = 1'b1; m1_addr = 32'hB0; m1_we = 4'b0000; m1_din = 32'h0;
        cyc();
        chk("sim_first_addr", 64'(s_addr), 64'hA0);
        s_ack = 1'b1; s_dout = 48'h1;
        cyc();
        s_ack = 1'b0;
        chk("sim_first_ack", 64'({m0_ack, m1_ack}), 64'b10);
        m0_stb = 1'b0;
        cyc(2);
        chk("sim_second_addr", 64'(s_addr), 64'hB0);
        s_ack = 1'b1; s_dout = 48'h2;
        cyc();
        s_ack = 1'b0;
        chk("sim_second_ack", 64'({m0_ack, m1_ack}), 64'b01);
        m1_stb = 1'b0;
        cyc(2);
        // both held continuously: 8 x m0, 1 x m1, repeating
        m0_stb = 1'b1; m0_addr = 32'h100;
        m1_stb = 1'b1; m1_addr = 32'h200;
        for (int k = 0; k < 18; k++) begin
            n = 0;
            while (!s_stb && n < 10) begin
                cyc();
                n++;
            end
            chk("burst_wait", 64'(s_stb), 1);
            exp_g = (k % 9) == 8;
            chk($sformatf("burst_gnt%0d", k), 64'(s_addr), exp_g ? 64'h200 : 64'h100);
            s_ack = 1'b1; s_dout = 48'(k);
            cyc();
            s_ack = 1'b0;
            chk($sformatf("burst_ack%0d", k), 64'({m0_ack, m1_ack}), exp_g ? 64'b01 : 64'b10);
        end
        m0_stb = 1'b0; m1_stb = 1'b0;
        cyc(2);
        chk("burst_last_m1_dout", 64'(m1_dout), 64'd17);
        // timeout: slave never acks, s_stb high for exactly 255 cycles
        m1_stb = 1'b1; m1_addr = 32'h80; m1_we = 4'hF; m1_din = 32'h1;
        cyc();
        n = 0;
        while (s_stb && n < 300) begin
            n++;
            cyc();
        end
        chk("tmo_busy_cycles", 64'(n), 64'd255);
        chk("tmo_ack_err", 64'({m0_ack, m1_ack, m1_err}), 64'b011);
        chk("tmo_dout", 64'(m1_dout), 0);
        m1_stb = 1'b0;
        cyc();
        chk("tmo_err_clear", 64'({m1_ack, m1_err}), 0);
        // s_ack in the final permitted BUSY cycle counts as success
        m1_stb = 1'b1;
        cyc(255);
        chk("edge_s_stb", 64'(s_stb), 1);
        s_ack = 1'b1; s_dout = 48'h5A5A;
        cyc();
        s_ack = 1'b0;
        chk("edge_ack_err", 64'({m1_ack, m1_err}), 64'b10);
        chk("edge_dout", 64'(m1_dout), 64'h5A5A);
        m1_stb = 1'b0;
        cyc();
        // reset during BUSY of an m1 write abandons it
        m1_stb = 1'b1; m1_addr = 32'h44; m1_we = 4'b1111; m1_din = 32'h12345678;
        cyc();
        chk("rmid_s_stb", 64'(s_stb), 1);
        rst = 1'b1;
        cyc();
        chk("rmid_s_stb_drop", 64'(s_stb), 0);
        chk("rmid_no_ack", 64'({m1_ack, m1_err}), 0);
        rst = 1'b0; m1_stb = 1'b0;
        cyc();
        chk("rmid_no_ack_after", 64'(m1_ack), 0);
        m0_stb = 1'b1; m0_addr = 32'h300;
        cyc();
        chk("rmid_m0_addr", 64'(s_addr), 64'h300);
        s_ack = 1'b1; s_dout = 48'hCAFE;
        cyc();
        s_ack = 1'b0;
        chk("rmid_m0_ack", 64'({m0_ack, m1_ack}), 64'b10);
        chk("rmid_m0_dout", 64'(m0_dout), 64'hCAFE);
        m0_stb = 1'b0;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/vram_sram_arbiter.md
VRAM_SRAM_ARBITER -- requirements
Module: vram_sram_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8: maximum consecutive m0 grants while m1 is pending.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum slave wait in cycles before an aborted grant (8-bit).
REQ-003 SHALL have port clkMem, in, 1: the clock. All logic is on its rising edge.
REQ-004 SHALL have port rst, in, 1: reset, synchronous, active-high.
REQ-005 SHALL have port m0_stb, in, 1: scan-out (VGA framebuffer) read request; held until m0_ack.
REQ-006 SHALL have port m0_addr, in, 32: m0 address.
REQ-007 SHALL have port m0_ack, out, 1: m0 completion; one-cycle pulse.
REQ-008 SHALL have port m0_dout, out, 48: m0 read data; valid while m0_ack=1.
REQ-009 SHALL have ports m1_stb (in, 1), m1_addr (in, 32), m1_we (in, 4), m1_din (in, 32): CPU request; held until m1_ack.
REQ-010 SHALL have ports m1_ack (out, 1), m1_dout (out, 48), m1_err (out, 1): CPU completion, read data, timeout flag.
REQ-011 SHALL have ports s_stb (out, 1), s_addr (out, 32), s_we (out, 4), s_din (out, 32): SRAM-side request.
REQ-012 SHALL have ports s_dout (in, 48), s_ack (in, 1): SRAM-side response; s_ack is a one-cycle completion.

Function
REQ-013 SHALL implement the states IDLE, BUSY, DONE; one transaction at a time; no pipelining.
REQ-014 IDLE: if any stb=1, SHALL register the grant (0 or 1), the address, the write enables and the write data, then go to BUSY; otherwise stay in IDLE.
REQ-015 Arbitration: SHALL grant m0 when m0_stb=1, unless m1_stb=1 and burst_cnt==MAX_BURST, in which case m1 is granted.
REQ-016 burst_cnt SHALL increment (saturating at MAX_BURST) on each m0 grant made while m1_stb=1, and SHALL clear on any m1 grant or when m1_stb=0 in IDLE.
REQ-017 For an m0 grant, s_we SHALL be 4'b0000 and s_din SHALL be 0: m0 is read-only.
REQ-018 BUSY: s_stb SHALL be 1, with s_addr, s_we and s_din stable from the registered copies.
REQ-019 Latency: a request sampled in IDLE at edge N SHALL give s_stb=1 in the cycle after edge N.
REQ-020 BUSY plus s_ack=1: SHALL latch s_dout into the granted master's dout, go to DONE, and drop s_stb at the same edge.
REQ-021 BUSY: a wait counter SHALL count cycles.
REQ-022 If the wait counter reaches TIMEOUT with no s_ack, SHALL drop s_stb, set dout=0, set err=1 (m1 only), and go to DONE.
REQ-023 DONE: SHALL assert exactly the granted master's ack for one cycle, then go to IDLE.
REQ-024 DONE: the non-granted ack SHALL stay 0.
REQ-025 A master whose stb is still high in DONE is not re-granted, because IDLE samples stb one cycle later, after the master has dropped it.
REQ-026 m1_err SHALL be valid only with m1_ack and SHALL be 0 otherwise.
REQ-027 s_ack outside BUSY SHALL be ignored.
REQ-028 m0_dout and m1_dout SHALL hold their last value until the next completion to the same master.
REQ-029 A master dropping stb mid-transaction SHALL NOT abort the transaction; it completes and acks normally.
REQ-030 s_ack arriving in the same cycle the wait counter reaches TIMEOUT SHALL count as success: err=0, data latched.
REQ-031 Minimum transaction length is 3 cycles (IDLE, BUSY, DONE); the bus is idle at least one cycle between grants.

Reset
REQ-032 While rst=1, SHALL hold: state=IDLE, s_stb=0, s_addr=0, s_we=0, s_din=0, m0_ack=0, m1_ack=0, m1_err=0, m0_dout=0, m1_dout=0, burst_cnt=0, wait counter=0.
REQ-033 rst asserted mid-transaction SHALL abandon it with no ack issued; s_stb=0 from the following cycle.

Verification
REQ-034 m0 read, addr 0x12C, s_ack 2 cycles after s_stb with s_dout=48'hABCD_1234_5678 -> m0_ack pulse with that data; 4 cycles from stb to ack.
REQ-035 m1 write, addr 0x40, we=4'b0011, din=0xDEADBEEF -> s_we=4'b0011, s_din=0xDEADBEEF while s_stb=1; m1_ack=1 with m1_err=0.
REQ-036 m0 and m1 both held continuously, MAX_BURST=8 -> grant sequence 8 x m0, 1 x m1, repeating; m1 is never starved.
REQ-037 m1 request, slave never acks, TIMEOUT=255 -> s_stb drops after 255 BUSY cycles; m1_ack=1, m1_err=1, m1_dout=0.
REQ-038 rst pulsed during BUSY of an m1 write -> s_stb=0 next cycle; no m1_ack; the next m0 request is serviced normally.
REQ-039 s_ack pulsed while IDLE, and simultaneous m0_stb/m1_stb with burst_cnt=0 -> spurious ack ignored; m0 granted first.
